// File: rtl/cpu_control_if.sv
// Fetch port and ALU control/status bundle between the sequencer (master) and memory/ALU (slave).
// Pure wiring: no latency; fetch is paced by mem_ready.
interface cpu_control_if;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] instruction;
    logic        exec1;
    logic        carrystatus;
    logic        skipstatus;
    logic        carryout;
    logic        carryen;
    logic        skipout;
    logic        skipen;

    modport master (
        output mem_addr, mem_rd, instruction, exec1, carrystatus, skipstatus,
        input  mem_rdata, mem_ready, carryout, carryen, skipout, skipen
    );

    modport slave (
        input  mem_addr, mem_rd, instruction, exec1, carrystatus, skipstatus,
        output mem_rdata, mem_ready, carryout, carryen, skipout, skipen
    );
endinterface

// File: rtl/cpu_control.sv
// Fetch/execute sequencer: owns PC, IR', CARRY, SKIP; executes JMP/HALT, drives the ALU.
// One instruction per (fetch wait + 1) cycles, min 2; fetch stalls in FETCH while mem_ready=0.
module cpu_control #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic          clk,
    input  logic          reset,
    cpu_control_if.master bus,
    output logic [15:0]   pc,
    output logic          halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC1 = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] ir;
    logic        carry;
    logic        skip;
    logic        mem_rd;
    logic        exec1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= FETCH;
            pc     <= RESET_PC;
            ir     <= 16'h0000;
            carry  <= 1'b0;
            skip   <= 1'b0;
            mem_rd <= 1'b1;
            exec1  <= 1'b0;
            halted <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (bus.mem_ready) begin
                        ir     <= bus.mem_rdata;
                        pc     <= pc + 16'd1;
                        state  <= EXEC1;
                        mem_rd <= 1'b0;
                        exec1  <= 1'b1;
                    end
                end
                EXEC1: begin
                    if (bus.carryen) carry <= bus.carryout;
                    if (bus.skipen)  skip  <= bus.skipout;
                    exec1 <= 1'b0;
                    // A pending SKIP turns JMP and HALT into NOPs; pc keeps its increment.
                    if (!skip && ir[15:12] == 4'b0001) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        state  <= FETCH;
                        mem_rd <= 1'b1;
                        if (!skip && ir[15:12] == 4'b0000) pc <= {4'b0000, ir[11:0]};
                    end
                end
                HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    state  <= FETCH;
                    mem_rd <= 1'b1;
                    exec1  <= 1'b0;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_addr    = pc;
    assign bus.mem_rd      = mem_rd;
    assign bus.exec1       = exec1;
    assign bus.instruction = ir;
    assign bus.carrystatus = carry;
    assign bus.skipstatus  = skip;

endmodule

// File: tb/tb_cpu_control.sv
// Randomized bench for cpu_control against an instruction-level reference model.
module tb_cpu_control;

    localparam logic [15:0] RST_PC = 16'hFFFE;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pc;
    logic        halted;

    cpu_control_if bus();

    cpu_control #(.RESET_PC(RST_PC)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .pc     (pc),
        .halted (halted)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Architectural reference state
    logic [15:0] m_pc, m_ir;
    logic        m_c, m_s, m_h;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_arch(input string ph);
        chk({ph, " pc"}, pc, m_pc);
        chk({ph, " addr"}, bus.mem_addr, m_pc);
        chk({ph, " instruction"}, bus.instruction, m_ir);
        chk({ph, " carry"}, bus.carrystatus, m_c);
        chk({ph, " skip"}, bus.skipstatus, m_s);
        chk({ph, " halted"}, halted, m_h);
    endtask

    task automatic idle_inputs();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 16'($urandom);
        bus.carryen   = 1'b0;
        bus.carryout  = 1'($urandom);
        bus.skipen    = 1'b0;
        bus.skipout   = 1'($urandom);
    endtask

    task automatic do_reset(input int cyc, input bit rdy_during);
        reset = 1'b1;
        bus.mem_ready = rdy_during;
        bus.mem_rdata = 16'($urandom);
        repeat (cyc) @(posedge clk);
        #1;
        reset = 1'b0;
        idle_inputs();
        m_pc = RST_PC; m_ir = 16'h0000; m_c = 1'b0; m_s = 1'b0; m_h = 1'b0;
        @(negedge clk);
        chk_arch("reset");
        chk("reset mem_rd", bus.mem_rd, 1'b1);
        chk("reset exec1", bus.exec1, 1'b0);
        @(posedge clk);
        #1;
    endtask

    // One instruction: lat stall cycles, one handshake cycle, one exec cycle.
    task automatic do_instr(input logic [15:0] w, input int lat,
                            input bit cen, input bit cout, input bit sen, input bit sout);
        for (int k = 0; k <= lat; k++) begin
            bus.mem_ready = (k == lat);
            bus.mem_rdata = (k == lat) ? w : 16'($urandom);
            @(negedge clk);
            chk_arch("fetch");
            chk("fetch mem_rd", bus.mem_rd, 1'b1);
            chk("fetch exec1", bus.exec1, 1'b0);
            @(posedge clk);
            #1;
        end
        m_ir = w;
        m_pc = m_pc + 16'd1;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 16'($urandom);
        bus.carryen = cen; bus.carryout = cout;
        bus.skipen  = sen; bus.skipout  = sout;
        @(negedge clk);
        chk_arch("exec");
        chk("exec exec1", bus.exec1, 1'b1);
        chk("exec mem_rd", bus.mem_rd, 1'b0);
        @(posedge clk);
        if (!m_s && m_ir[15:12] == 4'h0) m_pc = {4'h0, m_ir[11:0]};
        if (!m_s && m_ir[15:12] == 4'h1) m_h = 1'b1;
        if (cen) m_c = cout;
        if (sen) m_s = sout;
        #1;
        idle_inputs();
    endtask

    task automatic halt_hold(input int n);
        for (int k = 0; k < n; k++) begin
            bus.mem_ready = 1'($urandom);
            bus.mem_rdata = 16'($urandom);
            bus.carryen = 1'($urandom); bus.carryout = 1'($urandom);
            bus.skipen  = 1'($urandom); bus.skipout  = 1'($urandom);
            @(negedge clk);
            chk_arch("halt");
            chk("halt mem_rd", bus.mem_rd, 1'b0);
            chk("halt exec1", bus.exec1, 1'b0);
            @(posedge clk);
            #1;
        end
        idle_inputs();
    endtask

    initial begin
        logic [15:0] w;
        int          sel;
        bit          sen, sout;

        idle_inputs();
        m_pc = RST_PC; m_ir = 16'h0000; m_c = 1'b0; m_s = 1'b0; m_h = 1'b0;
        do_reset(2, 1'b0);

        // ADD words back to back across the 16-bit wrap
        do_instr(16'hC001, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        do_instr(16'hC012, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        do_instr(16'hC123, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        do_instr(16'h0005, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        do_instr(16'hC5A5, 3, 1'b0, 1'b0, 1'b1, 1'b0);

        // Carry set, then held with carryen low
        do_instr(16'hC111, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        do_instr(16'hC222, 1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Skipped JMP, then taken JMP, then JMP 7 and HALT at 7
        do_instr(16'hC333, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        do_instr(16'h0123, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        do_instr(16'h0123, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        do_instr(16'h0007, 2, 1'b0, 1'b0, 1'b1, 1'b0);
        do_instr(16'h1000, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        halt_hold(20);
        do_reset(1, 1'b1);

        // Flags set, then reset while a fetch is pending
        do_instr(16'hC000, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset(1, 1'b1);

        for (int i = 0; i < 400; i++) begin
            w   = 16'($urandom);
            sel = $urandom_range(0, 19);
            if (sel < 5)       w[15:12] = 4'h0;
            else if (sel == 5) w[15:12] = 4'h1;
            sen  = m_s ? 1'b1 : 1'($urandom);
            sout = m_s ? 1'b0 : 1'($urandom);
            do_instr(w, $urandom_range(0, 3), 1'($urandom), 1'($urandom), sen, sout);
            if (m_h) begin
                halt_hold($urandom_range(1, 5));
                do_reset($urandom_range(1, 2), 1'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
